// File: rtl/inst_loader.sv
// Byte-stream program loader that writes big-endian 32-bit words into instruction memory.
// Optional checksum byte after the image is enabled by defining INST_LOADER_CHECKSUM_EN.
module inst_loader #(
  parameter int unsigned BASE_ADDR = 0,
  parameter int unsigned MEM_BYTES = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        busy,
  output logic        done,
  output logic        err
);

  typedef enum logic [2:0] {
    IDLE, LEN_HI, LEN_LO, DATA, WRITE, CHK, DONE, ERR
  } state_t;

  localparam logic [31:0] SPACE = 32'(MEM_BYTES - BASE_ADDR);

  state_t      state, state_next;
  logic [31:0] addr;
  logic [31:0] word;
  logic [15:0] remaining;
  logic [7:0]  len_hi;
  logic [1:0]  byte_idx;
  logic        xfer;
  logic [15:0] len_word;
  logic        too_big;
`ifdef INST_LOADER_CHECKSUM_EN
  logic [7:0]  csum;
`endif

  assign xfer     = rx_valid && rx_ready;
  assign len_word = {len_hi, rx_data};
  // Byte span of the image is formed 32 bits wide so large counts never wrap.
  assign too_big  = {14'd0, len_word, 2'b00} > SPACE;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE, DONE, ERR: if (start) state_next = LEN_HI;
      LEN_HI:          if (xfer) state_next = LEN_LO;
      LEN_LO: begin
        if (xfer) begin
          if (len_word == 16'd0) state_next = DONE;
          else if (too_big)      state_next = ERR;
          else                   state_next = DATA;
        end
      end
      DATA:            if (xfer && byte_idx == 2'd3) state_next = WRITE;
      WRITE: begin
        if (remaining == 16'd1) begin
`ifdef INST_LOADER_CHECKSUM_EN
          state_next = CHK;
`else
          state_next = DONE;
`endif
        end else begin
          state_next = DATA;
        end
      end
`ifdef INST_LOADER_CHECKSUM_EN
      CHK:             if (xfer) state_next = (rx_data == csum) ? DONE : ERR;
`endif
      default:         state_next = IDLE;
    endcase
  end

  always_comb begin
    rx_ready  = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = 32'd0;
    mem_wdata = 32'd0;
    busy      = 1'b0;
    done      = 1'b0;
    err       = 1'b0;
    case (state)
      LEN_HI, LEN_LO, DATA, CHK: begin
        rx_ready = 1'b1;
        busy     = 1'b1;
      end
      WRITE: begin
        mem_we    = 1'b1;
        mem_addr  = addr;
        mem_wdata = word;
        busy      = 1'b1;
      end
      DONE:    done = 1'b1;
      ERR:     err  = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr      <= 32'd0;
      word      <= 32'd0;
      remaining <= 16'd0;
      len_hi    <= 8'd0;
      byte_idx  <= 2'd0;
`ifdef INST_LOADER_CHECKSUM_EN
      csum      <= 8'd0;
`endif
    end else begin
      case (state)
        IDLE, DONE, ERR: begin
          if (start) begin
            addr     <= 32'(BASE_ADDR);
            word     <= 32'd0;
            byte_idx <= 2'd0;
`ifdef INST_LOADER_CHECKSUM_EN
            csum     <= 8'd0;
`endif
          end
        end
        LEN_HI: if (xfer) len_hi <= rx_data;
        LEN_LO: begin
          if (xfer) begin
            remaining <= len_word;
            byte_idx  <= 2'd0;
          end
        end
        DATA: begin
          if (xfer) begin
            word     <= {word[23:0], rx_data};
            byte_idx <= byte_idx + 2'd1;
`ifdef INST_LOADER_CHECKSUM_EN
            csum     <= csum ^ rx_data;
`endif
          end
        end
        WRITE: begin
          addr      <= addr + 32'd4;
          remaining <= remaining - 16'd1;
          byte_idx  <= 2'd0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_inst_loader.sv
// Directed bench for inst_loader: writes are checked against a scoreboard of expected words.
module tb_inst_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  rx_data = 8'd0;
  logic        rx_valid = 1'b0;
  logic        rx_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        busy;
  logic        done;
  logic        err;

  int          checks = 0;
  int          failures = 0;
  logic [31:0] exp_addr[$];
  logic [31:0] exp_data[$];
  logic [31:0] next_addr;
  logic [31:0] last_addr;
  logic [7:0]  csum_acc;
  bit          gap_en = 1'b0;

  inst_loader dut (
    .clk(clk), .rst(rst), .start(start), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Every clock step passes through here, so the write port is watched on every cycle.
  task automatic tick();
    logic [31:0] a, d;
    @(posedge clk);
    #1;
    if (mem_we === 1'b1) begin
      check("write_rx_ready", {31'd0, rx_ready}, 32'd0);
      if (exp_addr.size() == 0) begin
        check("unexpected_write", {31'd0, mem_we}, 32'd0);
      end else begin
        a = exp_addr.pop_front();
        d = exp_data.pop_front();
        check("write_addr", mem_addr, a);
        check("write_data", mem_wdata, d);
        last_addr = mem_addr;
      end
    end else begin
      check("idle_addr", mem_addr, 32'd0);
      check("idle_wdata", mem_wdata, 32'd0);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    next_addr = 32'd0;
    csum_acc  = 8'd0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    bit accepted = 1'b0;
    int waited = 0;
    if (gap_en) begin
      rx_valid = 1'b0;
      repeat ($urandom_range(0, 2)) tick();
    end
    rx_valid = 1'b1;
    rx_data  = b;
    while (!accepted && waited < 50) begin
      accepted = (rx_ready === 1'b1);
      tick();
      waited++;
    end
    if (!accepted) check("accept_timeout", {31'd0, accepted}, 32'd1);
  endtask

  task automatic send_len(input logic [15:0] n);
    send_byte(n[15:8]);
    send_byte(n[7:0]);
  endtask

  task automatic send_word(input logic [31:0] w);
    exp_addr.push_back(next_addr);
    exp_data.push_back(w);
    next_addr = next_addr + 32'd4;
    csum_acc  = csum_acc ^ w[31:24] ^ w[23:16] ^ w[15:8] ^ w[7:0];
    send_byte(w[31:24]);
    send_byte(w[23:16]);
    send_byte(w[15:8]);
    send_byte(w[7:0]);
  endtask

  // Ends a non-empty image: the last write is in flight, one more step lands in DONE/ERR.
  task automatic end_stream(input logic [7:0] csum_delta);
`ifdef INST_LOADER_CHECKSUM_EN
    send_byte(csum_acc ^ csum_delta);
    rx_valid = 1'b0;
`else
    rx_valid = 1'b0;
    tick();
`endif
  endtask

  task automatic checkOutput(input string tag, input logic b, input logic d, input logic e);
    check({tag, "_busy"}, {31'd0, busy}, {31'd0, b});
    check({tag, "_done"}, {31'd0, done}, {31'd0, d});
    check({tag, "_err"}, {31'd0, err}, {31'd0, e});
    check({tag, "_ready"}, {31'd0, rx_ready}, 32'd0);
    check({tag, "_pending"}, exp_addr.size(), 32'd0);
  endtask

  initial begin
    // reset, with a simultaneous start that must lose
    rst = 1'b1; start = 1'b1;
    tick();
    rst = 1'b0; start = 1'b0;
    checkOutput("reset", 1'b0, 1'b0, 1'b0);
    tick();
    checkOutput("reset_hold", 1'b0, 1'b0, 1'b0);

    // basic load at full rate
    pulse_start();
    check("start_busy", {31'd0, busy}, 32'd1);
    send_len(16'd2);
    send_word(32'hDEADBEEF);
    send_word(32'h0000002A);
    end_stream(8'h00);
    checkOutput("basic", 1'b0, 1'b1, 1'b0);

    // zero length
    pulse_start();
    check("restart_done_clear", {31'd0, done}, 32'd0);
    send_len(16'd0);
    rx_valid = 1'b0;
    checkOutput("zero_len", 1'b0, 1'b1, 1'b0);

    // overflow by one word
    pulse_start();
    send_len(16'd65);
    rx_valid = 1'b0;
    checkOutput("overflow", 1'b0, 1'b0, 1'b1);
    tick();
    checkOutput("overflow_hold", 1'b0, 1'b0, 1'b1);

    // exactly fills the memory
    pulse_start();
    check("restart_err_clear", {31'd0, err}, 32'd0);
    send_len(16'd64);
    for (int i = 0; i < 64; i++) send_word(32'hA5000000 ^ (32'(i) * 32'h01010101));
    end_stream(8'h00);
    checkOutput("full", 1'b0, 1'b1, 1'b0);
    check("full_last_addr", last_addr, 32'h000000FC);

    // backpressure with a byte held through WRITE and a start while busy
    pulse_start();
    gap_en = 1'b1;
    send_len(16'd2);
    rx_valid = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("start_ignored_busy", {31'd0, busy}, 32'd1);
    send_word(32'hDEADBEEF);
    rx_valid = 1'b1;
    rx_data  = 8'h00;
    check("held_byte_write_ready", {31'd0, rx_ready}, 32'd0);
    gap_en = 1'b0;
    send_word(32'h0000002A);
    end_stream(8'h00);
    checkOutput("backpressure", 1'b0, 1'b1, 1'b0);

    // reset in the middle of a word
    pulse_start();
    send_len(16'd1);
    send_byte(8'hAA);
    send_byte(8'hBB);
    rx_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("mid_reset", 1'b0, 1'b0, 1'b0);
    check("mid_reset_we", {31'd0, mem_we}, 32'd0);
    repeat (3) tick();
    pulse_start();
    send_len(16'd1);
    send_word(32'h11223344);
    end_stream(8'h00);
    checkOutput("after_reset", 1'b0, 1'b1, 1'b0);

`ifdef INST_LOADER_CHECKSUM_EN
    // wrong checksum: the write still lands, then the load aborts
    pulse_start();
    send_len(16'd1);
    send_word(32'hDEADBEEF);
    end_stream(8'h01);
    checkOutput("bad_csum", 1'b0, 1'b0, 1'b1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/inst_loader.md
Name: inst_loader

Overview:
- Write-side companion to the instruction memory: receives a program image as a byte stream and writes it as 32-bit words into instruction memory.
- Word addresses are byte addresses stepping by 4.
- Replaces file-based program loading for in-system and bench loading.
- Holds the CPU off (busy) while loading; reports done or error.

Parameters:
- BASE_ADDR, 0: byte address of the first word written (multiple of 4).
- MEM_BYTES, 256: size of the instruction memory address space; addresses must stay below this value.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  one-cycle pulse that begins a load; honoured only in IDLE, DONE or ERR.
- rx_data  input  8  stream byte.
- rx_valid  input  1  rx_data is valid.
- rx_ready  output  1  loader accepts a byte this cycle; transfer occurs when rx_valid && rx_ready.
- mem_we  output  1  instruction-memory write strobe, exactly one cycle per word.
- mem_addr  output  32  byte address of the write.
- mem_wdata  output  32  word to write.
- busy  output  1  load in progress (any state other than IDLE, DONE, ERR).
- done  output  1  load completed successfully; held until next start or rst.
- err  output  1  load aborted; held until next start or rst.

Behaviour:
- Reset (rst=1 at a clk edge): state=IDLE; all outputs 0; byte and word counters cleared; partial word discarded. Applies mid-load too: no write occurs in the cycle after rst.
- Outputs are registered/state-decoded.
- Stream format: LEN_HI, LEN_LO (16-bit word count N, big-endian), then N words of 4 bytes each, big-endian (first byte -> [31:24]).
- IDLE/DONE/ERR: rx_ready=0. On start: clear done/err, addr=BASE_ADDR, go to LEN_HI.
- LEN_HI: rx_ready=1; on transfer, latch the high byte and go to LEN_LO.
- LEN_LO: rx_ready=1; on transfer, form N.
  - If N==0: go to DONE.
  - Else if 4*N > MEM_BYTES-BASE_ADDR (computed at least 18 bits wide, no truncation): go to ERR.
  - Else: go to DATA with byte index 0.
- DATA: rx_ready=1; each transfer shifts the byte into the word register. After the 4th byte, go to WRITE.
- WRITE: mem_we=1 for exactly that cycle, with mem_addr=current addr and mem_wdata=the assembled word; rx_ready=0, so a byte offered here is not consumed. Next cycle: addr+=4 and remaining-=1. If remaining becomes 0, go to DONE (or CHK with the optional feature); else go to DATA.
- mem_addr and mem_wdata are 0 whenever mem_we=0.
- Best-case throughput: 5 cycles per word.
- rx_valid gaps are allowed anywhere; the state holds.
- start while busy is ignored.
- start in the same cycle as rst: rst wins.
- DONE: done=1, busy=0. ERR: err=1, done=0, busy=0, and no mem_we ever asserted from this state.
- Words written before an error remain in memory (not rolled back).

Optional Feature:
- Macro: INST_LOADER_CHECKSUM_EN.
- Defined:
  - A running XOR of all data bytes (not length bytes) is kept, cleared on start.
  - After the last WRITE, go to CHK: rx_ready=1; accept one checksum byte.
  - If it equals the running XOR, go to DONE; else go to ERR.
- Undefined: no CHK state and no checksum byte; after the last WRITE, go directly to DONE.

Test Plan:
- Basic load: rst 1 cycle, start, bytes 00 02 DE AD BE EF 00 00 00 2A at full rate -> mem_we pulses (addr 0x0, data 0xDEADBEEF) and (addr 0x4, data 0x0000002A); done=1 the cycle after the 2nd write; busy=0; err=0.
- Zero length: start, bytes 00 00 -> no mem_we; done=1; rx_ready=0 afterwards.
- Overflow, MEM_BYTES=256: length 00 41 (65 words) -> err=1, no mem_we, rx_ready=0. Length 00 40 (64 words) is accepted, and its last write is at addr 0xFC.
- Backpressure: same stream as the basic load, with rx_valid low on random cycles and a byte held valid through the WRITE cycle -> identical writes; the held byte is consumed only after WRITE.
- Reset mid-load: rst after bytes 00 01 AA BB -> next cycle IDLE, all outputs 0, no write. Then start, 00 01 11 22 33 44 -> single write (0x0, 0x11223344); done=1.
- Checksum (macro defined): start, 00 01 DE AD BE EF 22 -> write then done=1. Repeat with checksum byte 23 -> write occurs, then err=1, done=0.
